controle_chaves: RTL and testbench

//  Player-input front end for astro_genius: conditions the six raw player switches and the start

---
 rtl/controle_chaves.sv | 103 ++++++++++
 tb/tb_controle_chaves.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/controle_chaves.sv
// Player-input front end: synchronizes and debounces the switches and start button,
// turns debounced presses into sticky pending bits and offers them under valid/ack.
module controle_chaves #(
  parameter int N_CHAVES        = 6,
  parameter int DEBOUNCE_CICLOS = 20,
  parameter int CONT_W          = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_CHAVES-1:0] botoes,
  input  logic                iniciar_bruto,
  output logic [N_CHAVES-1:0] chaves,
  output logic                chaves_valido,
  input  logic                chaves_ack,
  output logic                iniciar,
  output logic [1:0]          db_estado
);

  localparam int NB = N_CHAVES + 1;
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    OFERECE = 2'd1
  } estado_t;

  estado_t estado, proximo;
  logic    carrega;

  // Bit N_CHAVES of the conditioned vectors is the start button.
  logic [NB-1:0]     bruto, sync1, sync2, nivel, nivel_ant, press;
  logic [CONT_W-1:0] cont [NB];
  logic [N_CHAVES-1:0] pendentes;

  assign bruto = {iniciar_bruto, botoes};
  assign press = nivel & ~nivel_ant;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      nivel     <= '0;
      nivel_ant <= '0;
      for (int unsigned i = 0; i < NB; i++) cont[i] <= '0;
    end else begin
      sync1     <= bruto;
      sync2     <= sync1;
      nivel_ant <= nivel;
      // The level flips on the DEBOUNCE_CICLOS-th consecutive mismatching cycle.
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == nivel[i]) begin
          cont[i] <= '0;
        end else if (cont[i] == LIMITE) begin
          nivel[i] <= sync2[i];
          cont[i]  <= '0;
        end else begin
          cont[i] <= cont[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    proximo = estado;
    carrega = 1'b0;
    case (estado)
      ESPERA: begin
        if (pendentes != '0) begin
          carrega = 1'b1;
          proximo = OFERECE;
        end
      end
      OFERECE: begin
        if (chaves_ack) proximo = ESPERA;
      end
      default: proximo = ESPERA;
    endcase
  end

  // A press landing in the load cycle is OR-ed back in, so it survives for the next offer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= ESPERA;
      chaves        <= '0;
      chaves_valido <= 1'b0;
      pendentes     <= '0;
      iniciar       <= 1'b0;
    end else begin
      estado        <= proximo;
      chaves_valido <= (proximo == OFERECE);
      iniciar       <= press[N_CHAVES];
      if (carrega) begin
        chaves    <= pendentes;
        pendentes <= press[N_CHAVES-1:0];
      end else begin
        pendentes <= pendentes | press[N_CHAVES-1:0];
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_chaves.sv
// Directed bench for controle_chaves with a short debounce window and an offer scoreboard.
module tb_controle_chaves;

  localparam int N  = 6;
  localparam int DB = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes;
  logic         iniciar_bruto;
  logic [N-1:0] chaves;
  logic         chaves_valido;
  logic         chaves_ack;
  logic         iniciar;
  logic [1:0]   db_estado;

  int n_asserts = 0;
  int n_fail    = 0;
  int pulses    = 0;
  logic [N-1:0] sb[$];

  controle_chaves #(
    .N_CHAVES(N),
    .DEBOUNCE_CICLOS(DB),
    .CONT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .botoes(botoes),
    .iniciar_bruto(iniciar_bruto),
    .chaves(chaves),
    .chaves_valido(chaves_valido),
    .chaves_ack(chaves_ack),
    .iniciar(iniciar),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (iniciar === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_offer(input string tag, input int max);
    logic         seen;
    logic [N-1:0] exp;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clock);
      if (chaves_valido === 1'b1) seen = 1'b1;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_chaves"}, 32'(chaves), 32'(exp));
    check({tag, "_estado"}, 32'(db_estado), 32'd1);
  endtask

  task automatic watch_idle(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (chaves_valido !== 1'b0) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic ack_pulse(input string tag);
    chaves_ack = 1'b1;
    @(negedge clock);
    chaves_ack = 1'b0;
    check(tag, 32'(chaves_valido), 32'd0);
  endtask

  task automatic watch_stable(input string tag, input int n, input logic [N-1:0] ref_val);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (chaves_valido !== 1'b1 || chaves !== ref_val) bad = 1'b1;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    botoes        = 6'b111111;
    iniciar_bruto = 1'b0;
    chaves_ack    = 1'b0;

    // Reset with switches held
    repeat (5) @(negedge clock);
    check("rst_chaves", 32'(chaves), 32'd0);
    check("rst_valido", 32'(chaves_valido), 32'd0);
    check("rst_iniciar", 32'(iniciar), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    sb.push_back(6'b111111);
    wait_offer("after_rst", 10);
    ack_pulse("after_rst_ack");
    botoes = '0;
    watch_idle("release_idle", 12);

    // Two-bit command, long hold without ack
    botoes = 6'b010001;
    sb.push_back(6'b010001);
    wait_offer("cmd2", 9);
    watch_stable("cmd2_stable", 50, 6'b010001);
    ack_pulse("cmd2_ack");
    check("cmd2_ack_estado", 32'(db_estado), 32'd0);
    watch_idle("no_autorepeat", 20);
    botoes = '0;
    watch_idle("cmd2_release", 12);

    // Glitch shorter than the debounce window
    botoes[2] = 1'b1;
    repeat (DB - 1) @(negedge clock);
    botoes[2] = 1'b0;
    watch_idle("glitch", 15);

    // Press long enough to be accepted
    botoes[2] = 1'b1;
    sb.push_back(6'b000100);
    repeat (6) @(negedge clock);
    botoes[2] = 1'b0;
    wait_offer("press6", 6);

    // New press during an offer waits for the ack
    botoes[3] = 1'b1;
    sb.push_back(6'b001000);
    watch_stable("frozen", 14, 6'b000100);
    ack_pulse("frozen_ack");
    check("one_espera", 32'(db_estado), 32'd0);
    wait_offer("queued", 2);
    ack_pulse("queued_ack");
    botoes = '0;
    watch_idle("queued_release", 12);

    // Start button held: single pulse, FSM untouched
    iniciar_bruto = 1'b1;
    repeat (100) @(negedge clock);
    check("iniciar_once", 32'(pulses), 32'd1);
    check("iniciar_no_offer", 32'(chaves_valido), 32'd0);
    iniciar_bruto = 1'b0;
    repeat (12) @(negedge clock);
    check("iniciar_release", 32'(pulses), 32'd1);

    // Reset in the middle of an offer with another press pending
    botoes[1] = 1'b1;
    sb.push_back(6'b000010);
    wait_offer("pre_rst", 9);
    botoes[4] = 1'b1;
    repeat (12) @(negedge clock);
    reset  = 1'b0;
    botoes = '0;
    @(negedge clock);
    check("midrst_valido", 32'(chaves_valido), 32'd0);
    check("midrst_chaves", 32'(chaves), 32'd0);
    check("midrst_estado", 32'(db_estado), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    watch_idle("pend_cleared", 20);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
